// File: rtl/serial_adder_ctrl.sv
// ============================================================================
//  Module   : serial_adder_ctrl
//  Brief    : Bit-serial adder; one full-adder cell stepped LSB first.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_acc;
    logic             r_c;
    logic [CW-1:0]    r_cnt;

    logic             w_fs;
    logic             w_fc;
    logic [WIDTH-1:0] w_acc_next;

    assign w_fs       = r_sa[0] ^ r_sb[0] ^ r_c;
    assign w_fc       = (r_sa[0] & r_sb[0]) | ((r_sa[0] ^ r_sb[0]) & r_c);
    assign w_acc_next = {w_fs, r_acc[WIDTH-1:1]};

    assign ready = (r_state == S_IDLE);
    assign busy  = (r_state == S_RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_acc   <= '0;
            r_c     <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            co      <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_c     <= cin;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_c   <= w_fc;
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    // Result registers load on the edge entering DONE so they are valid with done.
                    if (r_cnt == C_LAST) begin
                        sum     <= w_acc_next;
                        co      <= w_fc;
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
// ============================================================================
//  Module   : tb_serial_adder_ctrl
//  Brief    : Directed and random bench for serial_adder_ctrl (WIDTH 8 and 2).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic       ready8, busy8, done8, co8;
    logic [7:0] sum8;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0;
    logic       cin2 = 1'b0;
    logic       ready2, busy2, done2, co2;
    logic [1:0] sum2;

    int errors = 0;
    int checks = 0;

    logic [7:0] prev_sum8 = '0;
    logic       prev_co8  = 1'b0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .ready(ready8), .busy(busy8), .done(done8), .sum(sum8), .co(co8)
    );

    serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .ready(ready2), .busy(busy2), .done(done2), .sum(sum2), .co(co2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One WIDTH=8 addition from an IDLE sync point; returns at the next IDLE sync point.
    task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input string tag);
        logic [8:0] exp;
        int lat, busy_cnt;
        bit ready_ok, hold_ok;
        exp = 9'(ia) + 9'(ib) + 9'(ic);
        check({tag, ".ready_idle"}, 64'(ready8), 64'd1);
        a8 = ia; b8 = ib; cin8 = ic; start8 = 1'b1;
        step();
        start8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        lat = 1; busy_cnt = 0; ready_ok = 1; hold_ok = 1;
        while (done8 !== 1'b1 && lat < 30) begin
            if (busy8 === 1'b1) busy_cnt++;
            if (ready8 !== 1'b0) ready_ok = 0;
            if (sum8 !== prev_sum8 || co8 !== prev_co8) hold_ok = 0;
            step();
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'd9);
        check({tag, ".busy_cycles"}, 64'(busy_cnt), 64'd8);
        check({tag, ".ready_low"}, 64'(ready_ok), 64'd1);
        check({tag, ".hold_prev"}, 64'(hold_ok), 64'd1);
        check({tag, ".sum"}, 64'(sum8), 64'(exp[7:0]));
        check({tag, ".co"}, 64'(co8), 64'(exp[8]));
        prev_sum8 = exp[7:0];
        prev_co8  = exp[8];
        step();
        check({tag, ".done_pulse"}, 64'(done8), 64'd0);
        check({tag, ".ready_back"}, 64'(ready8), 64'd1);
    endtask

    task automatic op2(input logic [1:0] ia, input logic [1:0] ib, input logic ic);
        logic [2:0] exp;
        int lat;
        exp = 3'(ia) + 3'(ib) + 3'(ic);
        a2 = ia; b2 = ib; cin2 = ic; start2 = 1'b1;
        step();
        start2 = 1'b0;
        a2 = 2'($urandom); b2 = 2'($urandom); cin2 = 1'($urandom);
        lat = 1;
        while (done2 !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        check("w2.latency", 64'(lat), 64'd3);
        check("w2.sum_co", 64'({co2, sum2}), 64'(exp));
        step();
    endtask

    initial begin
        int t1, t2, cyc, ndone, bad;
        logic [7:0] r1, r2;

        step();
        step();
        check("rst.ready", 64'(ready8), 64'd1);
        check("rst.busy", 64'(busy8), 64'd0);
        check("rst.done", 64'(done8), 64'd0);
        check("rst.sum", 64'(sum8), 64'd0);
        check("rst.co", 64'(co8), 64'd0);
        check("rst.w2", 64'({ready2, busy2, done2, co2, sum2}), 64'b100000);
        rst = 1'b0;

        op8(8'h5A, 8'h3C, 1'b0, "basic");
        op8(8'hFF, 8'h01, 1'b0, "ripple");
        op8(8'hFF, 8'hFF, 1'b1, "allones");

        // start held high across two operations, operand changed mid-flight
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        step();
        a8 = 8'h01;
        t1 = -1; t2 = -1; r1 = '0; r2 = '0;
        for (cyc = 1; cyc < 40 && t2 < 0; cyc++) begin
            if (done8 === 1'b1) begin
                if (t1 < 0) begin t1 = cyc; r1 = sum8; end
                else begin t2 = cyc; r2 = sum8; start8 = 1'b0; end
            end
            if (t2 < 0) step();
        end
        start8 = 1'b0;
        check("held.first_lat", 64'(t1), 64'd9);
        check("held.first_sum", 64'(r1), 64'h30);
        check("held.spacing", 64'(t2 - t1), 64'd10);
        check("held.second_sum", 64'(r2), 64'h21);
        step();
        check("held.idle", 64'(ready8), 64'd1);
        prev_sum8 = 8'h21; prev_co8 = 1'b0;

        // reset in the 4th RUN cycle
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; start8 = 1'b1;
        step();
        start8 = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst.ready", 64'(ready8), 64'd1);
        check("midrst.busy", 64'(busy8), 64'd0);
        check("midrst.sum", 64'(sum8), 64'd0);
        check("midrst.co", 64'(co8), 64'd0);
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done8 === 1'b1) ndone++;
            step();
        end
        check("midrst.no_done", 64'(ndone), 64'd0);
        prev_sum8 = '0; prev_co8 = 1'b0;
        op8(8'h01, 8'h01, 1'b0, "post_rst");

        // rst and start together in IDLE
        a8 = 8'h33; b8 = 8'h44; rst = 1'b1; start8 = 1'b1;
        step();
        rst = 1'b0; start8 = 1'b0;
        ndone = 0; bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8 === 1'b1) ndone++;
            if (ready8 !== 1'b1 || busy8 !== 1'b0) bad++;
            step();
        end
        check("rststart.no_done", 64'(ndone), 64'd0);
        check("rststart.stay_idle", 64'(bad), 64'd0);
        check("rststart.sum", 64'(sum8), 64'd0);
        prev_sum8 = '0; prev_co8 = 1'b0;

        for (int i = 0; i < 20; i++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), "rand8");

        for (int i = 0; i < 200; i++)
            op2(2'($urandom), 2'($urandom), 1'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
